hsv_to_rgb: RTL



---
 rtl/hsv_pkg.sv | 35 +++
 rtl/hsv_sector.sv | 45 ++++
 rtl/hsv_to_rgb.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hsv_pkg.sv
// Shared definitions for the HSV -> RGB decode path.
//
// Pixel word layout in the HSV domain: {H[23:15], S[14:8], V[7:0]}.
// Hue is 0..359 (codes 360..511 are illegal and clamp to 359), saturation is
// 0..127 and value is 0..255.
package hsv_pkg;

    // Field slices of the packed HSV word
    localparam int unsigned H_MSB = 23;
    localparam int unsigned H_LSB = 15;
    localparam int unsigned S_MSB = 14;
    localparam int unsigned S_LSB = 8;
    localparam int unsigned V_MSB = 7;
    localparam int unsigned V_LSB = 0;

    localparam int unsigned HUE_MAX  = 359;
    localparam int unsigned SECTOR_W = 60;

    // Q16 reciprocal of 60: x/60 ~= (x * 1093) >> 16
    localparam int unsigned RECIP_60_DEFAULT = 1093;

    // Register stages from pixel_in to pixel_out
    localparam int unsigned LATENCY = 4;

    // Hue sextant, named by the colour pair it spans
    typedef enum logic [2:0] {
        SEC_RY = 3'd0,
        SEC_YG = 3'd1,
        SEC_GC = 3'd2,
        SEC_CB = 3'd3,
        SEC_BM = 3'd4,
        SEC_MR = 3'd5
    } sector_e;

endpackage

// File: rtl/hsv_sector.sv
// Combinational hue decode: clamps hue to 0..359, then splits it into a
// 60-degree sector index and the offset inside that sector.
//
// Ports:
//   hue_i    - raw 9-bit hue code (360..511 treated as 359)
//   sector_o - sector index 0..5
//   frac_o   - offset inside the sector, 0..59
module hsv_sector
    import hsv_pkg::*;
(
    input  logic [8:0] hue_i,
    output sector_e    sector_o,
    output logic [5:0] frac_o
);

    logic [8:0] hue_clamped;
    logic [8:0] sector_base;

    always_comb begin
        // Illegal codes saturate at the top of the wheel rather than wrapping
        hue_clamped = (hue_i > 9'(HUE_MAX)) ? 9'(HUE_MAX) : hue_i;

        sector_o    = SEC_RY;
        sector_base = 9'd0;
        if (hue_clamped >= 9'(5 * SECTOR_W)) begin
            sector_o    = SEC_MR;
            sector_base = 9'(5 * SECTOR_W);
        end else if (hue_clamped >= 9'(4 * SECTOR_W)) begin
            sector_o    = SEC_BM;
            sector_base = 9'(4 * SECTOR_W);
        end else if (hue_clamped >= 9'(3 * SECTOR_W)) begin
            sector_o    = SEC_CB;
            sector_base = 9'(3 * SECTOR_W);
        end else if (hue_clamped >= 9'(2 * SECTOR_W)) begin
            sector_o    = SEC_GC;
            sector_base = 9'(2 * SECTOR_W);
        end else if (hue_clamped >= 9'(SECTOR_W)) begin
            sector_o    = SEC_YG;
            sector_base = 9'(SECTOR_W);
        end

        frac_o = 6'(hue_clamped - sector_base);
    end

endmodule

// File: rtl/hsv_to_rgb.sv
// Four-stage pipelined HSV -> RGB converter with a side-band word that is
// delayed in lock-step with the pixel. No back-pressure; every slot is
// computed whether or not it is valid.
//
// Optional build macro HSV_BYPASS_EN adds a 'bypass' input; a pixel sampled
// with bypass=1 leaves as its raw HSV word (same latency and alignment).
//
// Ports:
//   clk, rst_n  - pixel clock, asynchronous active-low reset
//   valid_in    - pixel_in / pass_in valid this cycle
//   pixel_in    - {H[23:15], S[14:8], V[7:0]}
//   pass_in     - side-band (sync/blank/coords)
//   valid_out   - pixel_out / pass_thru valid
//   pixel_out   - {R[23:16], G[15:8], B[7:0]}
//   pass_thru   - pass_in delayed by LATENCY cycles
module hsv_to_rgb
    import hsv_pkg::*;
#(
    parameter int unsigned PASS_W   = 24,
    parameter int unsigned RECIP_60 = RECIP_60_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
`ifdef HSV_BYPASS_EN
    input  logic              bypass,
`endif
    input  logic [23:0]       pixel_in,
    input  logic [PASS_W-1:0] pass_in,
    output logic              valid_out,
    output logic [23:0]       pixel_out,
    output logic [PASS_W-1:0] pass_thru
);

    // Alignment pipes
    logic [LATENCY-1:0] valid_q, valid_d;
    logic [PASS_W-1:0]  pass_q [LATENCY];
    logic [PASS_W-1:0]  pass_d [LATENCY];

    // Stage 1
    logic [7:0] v1_q, v1_d;
    logic [7:0] se1_q, se1_d;
    sector_e    sec1_q, sec1_d;
    logic [5:0] f1_q, f1_d;

    // Stage 2
    logic [7:0]  v2_q, v2_d;
    sector_e     sec2_q, sec2_d;
    logic [15:0] pv2_q, pv2_d;
    logic [12:0] a2_q, a2_d;
    logic [12:0] b2_q, b2_d;

    // Stage 3
    logic [7:0] v3_q, v3_d;
    sector_e    sec3_q, sec3_d;
    logic [7:0] p3_q, p3_d;
    logic [7:0] am3_q, am3_d;
    logic [7:0] bm3_q, bm3_d;

    // Stage 4
    logic [23:0] pix4_q, pix4_d;

`ifdef HSV_BYPASS_EN
    logic [LATENCY-2:0] byp_q, byp_d;
    logic [23:0]        raw_q [LATENCY-1];
    logic [23:0]        raw_d [LATENCY-1];
`endif

    // Hue decode
    sector_e    sec_in;
    logic [5:0] frac_in;
    logic [6:0] s_in;

    hsv_sector u_sector (
        .hue_i    (pixel_in[H_MSB:H_LSB]),
        .sector_o (sec_in),
        .frac_o   (frac_in)
    );

    logic [7:0] q4, t4;
    logic [7:0] r4, g4, b4;

    always_comb begin
        valid_d   = {valid_q[LATENCY-2:0], valid_in};
        pass_d[0] = pass_in;
        for (int i = 1; i < LATENCY; i++) begin
            pass_d[i] = pass_q[i-1];
        end

        // Stage 1: S=127 is stretched to 128 so that full saturation is exact
        s_in   = pixel_in[S_MSB:S_LSB];
        v1_d   = pixel_in[V_MSB:V_LSB];
        se1_d  = {1'b0, s_in} + {7'd0, s_in[6]};
        sec1_d = sec_in;
        f1_d   = frac_in;

        // Stage 2: raw products
        v2_d   = v1_q;
        sec2_d = sec1_q;
        pv2_d  = 16'(v1_q) * 16'(se1_q);
        a2_d   = 13'(se1_q) * 13'(f1_q);
        b2_d   = 13'(se1_q) * (13'(SECTOR_W) - 13'(f1_q));

        // Stage 3: p, and ramp factors normalised to 0..128 by dividing by 60
        v3_d   = v2_q;
        sec3_d = sec2_q;
        p3_d   = v2_q - 8'(pv2_q >> 7);
        am3_d  = 8'((32'(a2_q) * RECIP_60) >> 16);
        bm3_d  = 8'((32'(b2_q) * RECIP_60) >> 16);

        // Stage 4: falling (q) and rising (t) channels, then sector mux
        q4 = v3_q - 8'((16'(v3_q) * 16'(am3_q)) >> 7);
        t4 = v3_q - 8'((16'(v3_q) * 16'(bm3_q)) >> 7);
        r4 = v3_q;
        g4 = v3_q;
        b4 = v3_q;
        unique case (sec3_q)
            SEC_RY: begin r4 = v3_q; g4 = t4;   b4 = p3_q; end
            SEC_YG: begin r4 = q4;   g4 = v3_q; b4 = p3_q; end
            SEC_GC: begin r4 = p3_q; g4 = v3_q; b4 = t4;   end
            SEC_CB: begin r4 = p3_q; g4 = q4;   b4 = v3_q; end
            SEC_BM: begin r4 = t4;   g4 = p3_q; b4 = v3_q; end
            SEC_MR: begin r4 = v3_q; g4 = p3_q; b4 = q4;   end
            default: ;
        endcase
        pix4_d = {r4, g4, b4};

`ifdef HSV_BYPASS_EN
        byp_d    = {byp_q[LATENCY-3:0], bypass};
        raw_d[0] = pixel_in;
        for (int i = 1; i < LATENCY - 1; i++) begin
            raw_d[i] = raw_q[i-1];
        end
        if (byp_q[LATENCY-2]) begin
            pix4_d = raw_q[LATENCY-2];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pass_q[i] <= '0;
            end
            v1_q   <= '0;
            se1_q  <= '0;
            sec1_q <= SEC_RY;
            f1_q   <= '0;
            v2_q   <= '0;
            sec2_q <= SEC_RY;
            pv2_q  <= '0;
            a2_q   <= '0;
            b2_q   <= '0;
            v3_q   <= '0;
            sec3_q <= SEC_RY;
            p3_q   <= '0;
            am3_q  <= '0;
            bm3_q  <= '0;
            pix4_q <= '0;
`ifdef HSV_BYPASS_EN
            byp_q <= '0;
            for (int i = 0; i < LATENCY - 1; i++) begin
                raw_q[i] <= '0;
            end
`endif
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < LATENCY; i++) begin
                pass_q[i] <= pass_d[i];
            end
            v1_q   <= v1_d;
            se1_q  <= se1_d;
            sec1_q <= sec1_d;
            f1_q   <= f1_d;
            v2_q   <= v2_d;
            sec2_q <= sec2_d;
            pv2_q  <= pv2_d;
            a2_q   <= a2_d;
            b2_q   <= b2_d;
            v3_q   <= v3_d;
            sec3_q <= sec3_d;
            p3_q   <= p3_d;
            am3_q  <= am3_d;
            bm3_q  <= bm3_d;
            pix4_q <= pix4_d;
`ifdef HSV_BYPASS_EN
            byp_q <= byp_d;
            for (int i = 0; i < LATENCY - 1; i++) begin
                raw_q[i] <= raw_d[i];
            end
`endif
        end
    end

    assign valid_out = valid_q[LATENCY-1];
    assign pass_thru = pass_q[LATENCY-1];
    assign pixel_out = pix4_q;

endmodule
